adc_sample_fifo: RTL and testbench

ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

---
 rtl/adc_sample_fifo_if.sv | 52 +++++
 rtl/adc_sample_fifo.sv | 145 ++++++++++++++
 tb/tb_adc_sample_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_fifo_if.sv
// Handshake and data bundle between the ADC
// controller / SPI register side and the sample FIFO.
interface adc_sample_fifo_if #(
  parameter int ADC_WIDTH = 12,
  parameter int AW        = 3
);
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 adc_ack;
  logic                 enable;
  logic [1:0]           avg_sel;
  logic                 rd_en;
  logic                 clr_ovf;
  logic [AW:0]          thresh;
  logic [ADC_WIDTH-1:0] rd_data;
  logic [AW:0]          count;
  logic                 empty;
  logic                 full;
  logic                 overflow;
  logic                 irq;

  modport master (
    output adc_data,
    output adc_ack,
    output enable,
    output avg_sel,
    output rd_en,
    output clr_ovf,
    output thresh,
    input  rd_data,
    input  count,
    input  empty,
    input  full,
    input  overflow,
    input  irq
  );

  modport slave (
    input  adc_data,
    input  adc_ack,
    input  enable,
    input  avg_sel,
    input  rd_en,
    input  clr_ovf,
    input  thresh,
    output rd_data,
    output count,
    output empty,
    output full,
    output overflow,
    output irq
  );
endinterface

// File: rtl/adc_sample_fifo.sv
// ADC result capture: ack synchronizer, power-of-two
// averaging accumulator and FWFT sample FIFO with watermark irq.
module adc_sample_fifo #(
  parameter int ADC_WIDTH = 12,
  parameter int DEPTH     = 8,
  parameter int AW        = 3
) (
  input  logic              sys_clk,
  input  logic              reset,
  adc_sample_fifo_if.slave  bus
);
  localparam int SW = ADC_WIDTH + 3;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic ack_s1_q;
  logic ack_s2_q;
  logic ack_s3_q;
  logic stb_q;

  logic [SW-1:0]        acc_q, acc_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [1:0]           avg_q, avg_d;
  logic                 res_vld_q, res_vld_d;
  logic [ADC_WIDTH-1:0] res_q, res_d;
  logic [SW-1:0]        sum;
  logic [3:0]           cnt_inc;
  logic [3:0]           n_tgt;

  logic [ADC_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 irq_q, irq_d;
  logic                 empty;
  logic                 full;
  logic                 do_rd;
  logic                 do_wr;
  logic                 drop;

  // adc_data is quasi-static while ack is high, so only ack is synchronized
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
      ack_s3_q <= 1'b0;
      stb_q    <= 1'b0;
    end else begin
      ack_s1_q <= bus.adc_ack;
      ack_s2_q <= ack_s1_q;
      ack_s3_q <= ack_s2_q;
      stb_q    <= ack_s2_q & ~ack_s3_q;
    end
  end

  always_comb begin
    sum       = acc_q + SW'(bus.adc_data);
    cnt_inc   = {1'b0, cnt_q} + 4'd1;
    n_tgt     = 4'd1 << avg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    res_vld_d = 1'b0;
    res_d     = res_q;
    if (!bus.enable || (bus.avg_sel != avg_q)) begin
      acc_d = '0;
      cnt_d = '0;
      avg_d = bus.avg_sel;
    end else if (stb_q) begin
      if (cnt_inc == n_tgt) begin
        res_vld_d = 1'b1;
        res_d     = ADC_WIDTH'(sum >> avg_q);
        acc_d     = '0;
        cnt_d     = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc[2:0];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_q     <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
    end
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign do_rd = bus.rd_en & ~empty;
  // a pop frees the slot, so a full FIFO still takes the write
  assign do_wr = res_vld_q & (~full | do_rd);
  assign drop  = res_vld_q & full & ~do_rd;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    if (!do_wr && do_rd) count_d = count_q - 1'b1;
    if (drop)             ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
    irq_d = ((bus.thresh != '0) && (count_q >= bus.thresh)) || ovf_q;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= res_q;
  end

  assign bus.rd_data  = mem_q[rd_ptr_q];
  assign bus.count    = count_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overflow = ovf_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed bench for adc_sample_fifo: averaging, FIFO
// boundaries, overflow, watermark irq and reset behaviour.
module tb_adc_sample_fifo;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  adc_sample_fifo_if #(.ADC_WIDTH(12), .AW(3)) bus ();

  adc_sample_fifo #(
    .ADC_WIDTH(12),
    .DEPTH(8),
    .AW(3)
  ) dut (
    .sys_clk(clk),
    .reset(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // idle, raise ack with data, return just after the FIFO write edge
  task automatic send(input logic [11:0] d, input logic pop);
    repeat (4) @(negedge clk);
    bus.adc_data = d;
    bus.adc_ack  = 1'b1;
    repeat (4) @(negedge clk);
    if (pop) bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en   = 1'b0;
    bus.adc_ack = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [11:0] e);
    chk(tag, 32'(bus.rd_data), 32'(e));
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.adc_data = '0;
    bus.adc_ack  = 1'b0;
    bus.enable   = 1'b0;
    bus.avg_sel  = 2'd0;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    bus.thresh   = '0;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);
    chk("rst_irq", 32'(bus.irq), 0);
    rst        = 1'b0;
    bus.enable = 1'b1;
    @(negedge clk);

    // raw pass-through
    send(12'h123, 1'b0);
    send(12'h456, 1'b0);
    send(12'h789, 1'b0);
    chk("raw_count", 32'(bus.count), 3);
    pop_chk("raw_pop0", 12'h123);
    pop_chk("raw_pop1", 12'h456);
    pop_chk("raw_pop2", 12'h789);
    chk("raw_empty", 32'(bus.empty), 1);

    // average of four
    bus.avg_sel = 2'd2;
    repeat (2) @(negedge clk);
    send(12'h100, 1'b0);
    send(12'h101, 1'b0);
    send(12'h102, 1'b0);
    chk("avg4_partial", 32'(bus.count), 0);
    send(12'h104, 1'b0);
    chk("avg4_count", 32'(bus.count), 1);
    pop_chk("avg4_val", 12'h101);

    // average of eight full-scale samples
    bus.avg_sel = 2'd3;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) send(12'hFFF, 1'b0);
    chk("avg8_partial", 32'(bus.count), 0);
    send(12'hFFF, 1'b0);
    chk("avg8_count", 32'(bus.count), 1);
    pop_chk("avg8_val", 12'hFFF);

    // watermark
    bus.avg_sel = 2'd0;
    bus.thresh  = 4'd4;
    repeat (2) @(negedge clk);
    send(12'h001, 1'b0);
    send(12'h002, 1'b0);
    send(12'h003, 1'b0);
    chk("wm_irq_low", 32'(bus.irq), 0);
    send(12'h004, 1'b0);
    chk("wm_count4", 32'(bus.count), 4);
    chk("wm_irq_lag", 32'(bus.irq), 0);
    @(negedge clk);
    chk("wm_irq_rise", 32'(bus.irq), 1);
    pop_chk("wm_pop", 12'h001);
    chk("wm_count3", 32'(bus.count), 3);
    chk("wm_irq_hold", 32'(bus.irq), 1);
    @(negedge clk);
    chk("wm_irq_fall", 32'(bus.irq), 0);
    pop_chk("wm_d1", 12'h002);
    pop_chk("wm_d2", 12'h003);
    pop_chk("wm_d3", 12'h004);
    bus.thresh = '0;

    // fill and overflow
    for (int i = 0; i < 8; i++) send(12'(16 + i), 1'b0);
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), 8);
    chk("fill_ovf0", 32'(bus.overflow), 0);
    send(12'h018, 1'b0);
    chk("drop_count", 32'(bus.count), 8);
    chk("drop_ovf", 32'(bus.overflow), 1);
    @(negedge clk);
    chk("drop_irq", 32'(bus.irq), 1);
    chk("drop_head", 32'(bus.rd_data), 32'h010);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 0);
    @(negedge clk);
    chk("clr_irq", 32'(bus.irq), 0);

    // write and pop together while full
    send(12'h020, 1'b1);
    chk("wp_count", 32'(bus.count), 8);
    chk("wp_ovf", 32'(bus.overflow), 0);
    for (int i = 1; i < 8; i++) pop_chk("wp_drain", 12'(16 + i));
    pop_chk("wp_newest", 12'h020);
    chk("wp_empty", 32'(bus.empty), 1);

    // enable low discards the partial sum
    bus.avg_sel = 2'd1;
    repeat (2) @(negedge clk);
    send(12'h200, 1'b0);
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
    send(12'h300, 1'b0);
    chk("en_partial", 32'(bus.count), 0);
    send(12'h301, 1'b0);
    chk("en_count", 32'(bus.count), 1);
    pop_chk("en_val", 12'h300);

    // reset mid-fill, ack already high at release
    bus.avg_sel = 2'd0;
    repeat (2) @(negedge clk);
    send(12'h055, 1'b0);
    bus.adc_data = 12'h0AB;
    bus.adc_ack  = 1'b1;
    rst          = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rel_count", 32'(bus.count), 1);
    chk("rel_data", 32'(bus.rd_data), 32'h0AB);
    repeat (4) @(negedge clk);
    chk("rel_once", 32'(bus.count), 1);
    bus.adc_ack = 1'b0;
    pop_chk("rel_pop", 12'h0AB);
    chk("rel_empty", 32'(bus.empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
